hc_stream_sequencer: RTL and testbench

Sequences a multi-line read-modify-write job over the CCI-P memory channels for HardCloud AFUs. It issues N cache-line reads from a source buffer and tags each with its line index. Responses may arrive out of order; each is transformed and buffered, then written to the same index in a destination buffer. After every data write is acknowledged, it writes a completion line to DSM. It sits between the CSR block (start/stop, buffer addresses, line count) and the registered CCI-P Tx/Rx structures.

---
 rtl/hc_stream_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_hc_stream_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_stream_sequencer.sv
// hc_stream_sequencer
//   Runs one read-modify-write job over the CCI-P channels. It reads
//   num_lines cache lines from src_base, tagging each request with its line
//   index. Each response, possibly out of order, has ADD_CONST added to every
//   32-bit lane and is queued. Queued lines are written to dst_base+index.
//   Once every data write is acknowledged, a completion line goes to
//   dsm_base+1.
//
//   Optional build macro HC_SEQ_PERF_CNT_EN: adds a saturating 32-bit busy
//   cycle counter, reported in status data[95:64] (zero when not built).
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start, stop        job start pulse (IDLE only), done acknowledge (DONE only)
//   num_lines          cache lines in the job
//   src/dst/dsm_base   cache-line base addresses
//   c0_almfull         read-channel back-pressure
//   rd_req_*           read request: valid, address, line-index tag
//   rd_rsp_*           read response: valid, tag, line data
//   c1_almfull         write-channel back-pressure
//   wr_req_*           single-beat write request: valid, address, data
//   wr_rsp_valid       one write acknowledge per write
//   busy, done         job in progress (RUN/DRAIN/STATUS), job complete

`timescale 1ns/1ps

module hc_stream_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADD_CONST  = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [15:0]  num_lines,
    input  logic [41:0]  src_base,
    input  logic [41:0]  dst_base,
    input  logic [41:0]  dsm_base,
    input  logic         c0_almfull,
    output logic         rd_req_valid,
    output logic [41:0]  rd_req_addr,
    output logic [15:0]  rd_req_mdata,
    input  logic         rd_rsp_valid,
    input  logic [15:0]  rd_rsp_mdata,
    input  logic [511:0] rd_rsp_data,
    input  logic         c1_almfull,
    output logic         wr_req_valid,
    output logic [41:0]  wr_req_addr,
    output logic [511:0] wr_req_data,
    input  logic         wr_rsp_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_STATUS, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [15:0]  r_num_lines;
    logic [41:0]  r_src, r_dst, r_dsm;
    logic [15:0]  r_rd_issued, r_rd_received, r_wr_acked;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_fifo_count;
    logic         r_status_sent;
    logic [15:0]  r_fifo_idx  [FIFO_DEPTH];
    logic [511:0] r_fifo_data [FIFO_DEPTH];

    logic         r_rd_req_valid, r_wr_req_valid, r_busy, r_done;
    logic [41:0]  r_rd_req_addr, r_wr_req_addr;
    logic [15:0]  r_rd_req_mdata;
    logic [511:0] r_wr_req_data;

    logic         w_active, w_start, w_credit, w_rd_fire, w_push, w_pop;
    logic         w_fifo_empty, w_fifo_full, w_status_fire;
    logic [15:0]  w_outstanding;
    logic [511:0] w_xform, w_status_data;
    logic [31:0]  w_perf;

`ifdef HC_SEQ_PERF_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_start) begin
            r_cycles <= '0;
        end else if ((r_state == S_RUN || r_state == S_DRAIN || r_state == S_STATUS)
                     && r_cycles != '1) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_perf = r_cycles;
`else
    assign w_perf = '0;
`endif

    always_comb begin
        w_active      = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_start       = (r_state == S_IDLE) && start;
        w_outstanding = r_rd_issued - r_rd_received;
        // Reads in flight plus queued lines must fit the buffer, so a
        // response can never find it full.
        w_credit      = (17'(w_outstanding) + 17'(r_fifo_count)) < 17'(FIFO_DEPTH);
        w_rd_fire     = (r_state == S_RUN) && (r_rd_issued < r_num_lines)
                        && !c0_almfull && w_credit;
        w_fifo_empty  = (r_fifo_count == '0);
        w_fifo_full   = (r_fifo_count == CW'(FIFO_DEPTH));
        w_push        = w_active && rd_rsp_valid;
        w_pop         = w_active && !w_fifo_empty && !c1_almfull;
        w_status_fire = (r_state == S_STATUS) && !r_status_sent && !c1_almfull;

        w_xform = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            w_xform[32*i +: 32] = rd_rsp_data[32*i +: 32] + 32'(ADD_CONST);
        end

        w_status_data         = '0;
        w_status_data[31:0]   = 32'd1;
        w_status_data[47:32]  = r_num_lines;
        w_status_data[95:64]  = w_perf;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = (num_lines == '0) ? S_STATUS : S_RUN;
            S_RUN:    if (r_rd_issued == r_num_lines) w_state_next = S_DRAIN;
            S_DRAIN:  if ((r_wr_acked == r_num_lines) && w_fifo_empty && !r_wr_req_valid)
                          w_state_next = S_STATUS;
            S_STATUS: if (r_status_sent && wr_rsp_valid) w_state_next = S_DONE;
            S_DONE:   if (stop) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Buffer storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr]  <= rd_rsp_mdata;
            r_fifo_data[r_wr_ptr] <= w_xform;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_lines    <= '0;
            r_src          <= '0;
            r_dst          <= '0;
            r_dsm          <= '0;
            r_rd_issued    <= '0;
            r_rd_received  <= '0;
            r_wr_acked     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_count   <= '0;
            r_status_sent  <= 1'b0;
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_rd_req_mdata <= '0;
            r_wr_req_valid <= 1'b0;
            r_wr_req_addr  <= '0;
            r_wr_req_data  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_rd_req_valid <= w_rd_fire;
            r_wr_req_valid <= w_pop || w_status_fire;
            r_busy <= (w_state_next == S_RUN) || (w_state_next == S_DRAIN)
                      || (w_state_next == S_STATUS);
            r_done <= (w_state_next == S_DONE);

            if (w_start) begin
                r_num_lines   <= num_lines;
                r_src         <= src_base;
                r_dst         <= dst_base;
                r_dsm         <= dsm_base;
                r_rd_issued   <= '0;
                r_rd_received <= '0;
                r_wr_acked    <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_fifo_count  <= '0;
                r_status_sent <= 1'b0;
            end else begin
                if (w_rd_fire) begin
                    r_rd_req_addr  <= r_src + 42'(r_rd_issued);
                    r_rd_req_mdata <= r_rd_issued;
                    r_rd_issued    <= r_rd_issued + 16'd1;
                end
                if (w_push) begin
                    r_rd_received <= r_rd_received + 16'd1;
                    r_wr_ptr      <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_wr_req_addr <= r_dst + 42'(r_fifo_idx[r_rd_ptr]);
                    r_wr_req_data <= r_fifo_data[r_rd_ptr];
                    r_rd_ptr      <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                    2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                    default: r_fifo_count <= r_fifo_count;
                endcase
                if (w_active && wr_rsp_valid) r_wr_acked <= r_wr_acked + 16'd1;
                if (w_status_fire) begin
                    r_wr_req_addr <= r_dsm + 42'd1;
                    r_wr_req_data <= w_status_data;
                    r_status_sent <= 1'b1;
                end
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(w_push && w_fifo_full))
        else $error("read response pushed into a full response buffer");

    assign rd_req_valid = r_rd_req_valid;
    assign rd_req_addr  = r_rd_req_addr;
    assign rd_req_mdata = r_rd_req_mdata;
    assign wr_req_valid = r_wr_req_valid;
    assign wr_req_addr  = r_wr_req_addr;
    assign wr_req_data  = r_wr_req_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_hc_stream_sequencer.sv
`timescale 1ns/1ps

module tb_hc_stream_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] ADDC  = 32'd10;

    logic         clk, reset, start, stop;
    logic [15:0]  num_lines;
    logic [41:0]  src_base, dst_base, dsm_base;
    logic         c0_almfull, c1_almfull;
    logic         rd_req_valid, rd_rsp_valid, wr_req_valid, wr_rsp_valid;
    logic [41:0]  rd_req_addr, wr_req_addr;
    logic [15:0]  rd_req_mdata, rd_rsp_mdata;
    logic [511:0] rd_rsp_data, wr_req_data;
    logic         busy, done;

    hc_stream_sequencer #(.FIFO_DEPTH(DEPTH), .ADD_CONST(10)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .num_lines(num_lines), .src_base(src_base), .dst_base(dst_base),
        .dsm_base(dsm_base), .c0_almfull(c0_almfull),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_mdata(rd_req_mdata), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .c1_almfull(c1_almfull), .wr_req_valid(wr_req_valid),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [41:0]  addr;
        logic [511:0] data;
    } wr_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [41:0] exp_rd_addr_q[$];
    logic [15:0] exp_rd_tag_q[$];
    wr_t         exp_wr_q[$];
    logic [15:0] pend_q[$];
    logic [15:0] perm_q[$];
    int          ack_q[$];

    int          g_n, g_mode, g_c1_hold;
    logic [41:0] g_src, g_dst, g_dsm;
    int          rd_cnt, wr_data_cnt, status_cnt, c1_viol, max_inflight;
    logic        prev_c1;
    logic [41:0] first_wr_addr;
    logic [511:0] first_wr_data, last_status_data;

    function automatic logic [511:0] line_for(input int tag);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) begin
            if (tag != 0 && j == 15) d[32*j +: 32] = 32'hFFFF_FFF8 + 32'(tag);
            else                     d[32*j +: 32] = 32'(tag * 16 + j);
        end
        return d;
    endfunction

    function automatic logic [511:0] xform(input logic [511:0] d);
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[32*j +: 32] = d[32*j +: 32] + ADDC;
        return r;
    endfunction

    function automatic logic [511:0] status_line(input int n);
        logic [511:0] s;
        s = '0;
        s[31:0]  = 32'd1;
        s[47:32] = 16'(n);
        return s;
    endfunction

    // One clock: score DUT outputs at the falling edge, then drive responses.
    task automatic step();
        logic [41:0]  ea;
        logic [15:0]  et, tag;
        logic [511:0] act, line;
        wr_t          w;
        bit           send;
        @(negedge clk);
        if (rd_req_valid) begin
            rd_cnt++;
            n_checks++;
            if (exp_rd_addr_q.size() == 0) begin
                $display("FAIL rd_unexpected addr=%h tag=%0d required none", rd_req_addr, rd_req_mdata);
            end else begin
                ea = exp_rd_addr_q.pop_front();
                et = exp_rd_tag_q.pop_front();
                if (rd_req_addr !== ea || rd_req_mdata !== et)
                    $display("FAIL rd_req addr=%h tag=%0d required addr=%h tag=%0d",
                             rd_req_addr, rd_req_mdata, ea, et);
                else n_pass++;
            end
            pend_q.push_back(rd_req_mdata);
        end
        if (wr_req_valid) begin
            ack_q.push_back(int'($urandom_range(1, 4)));
            n_checks++;
            if (wr_data_cnt < g_n) begin
                if (wr_data_cnt == 0) begin
                    first_wr_addr = wr_req_addr;
                    first_wr_data = wr_req_data;
                end
                wr_data_cnt++;
                if (exp_wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected addr=%h required none", wr_req_addr);
                end else begin
                    w = exp_wr_q.pop_front();
                    if (wr_req_addr !== w.addr || wr_req_data !== w.data)
                        $display("FAIL wr_req addr=%h data[63:0]=%h required addr=%h data[63:0]=%h",
                                 wr_req_addr, wr_req_data[63:0], w.addr, w.data[63:0]);
                    else n_pass++;
                end
            end else begin
                status_cnt++;
                act = wr_req_data;
                last_status_data = wr_req_data;
`ifdef HC_SEQ_PERF_CNT_EN
                act[95:64] = '0;
`endif
                if (wr_req_addr !== g_dsm + 42'd1 || act !== status_line(g_n))
                    $display("FAIL status_wr addr=%h data[95:0]=%h required addr=%h data[95:0]=%h",
                             wr_req_addr, act[95:0], g_dsm + 42'd1, status_line(g_n) & 512'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
                else n_pass++;
            end
        end
        if (prev_c1 && wr_req_valid) c1_viol++;
        if (rd_cnt - wr_data_cnt > max_inflight) max_inflight = rd_cnt - wr_data_cnt;

        rd_rsp_valid = 1'b0;
        wr_rsp_valid = 1'b0;
        send = 1'b0;
        tag  = '0;
        if (g_mode == 0 && pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            tag = pend_q.pop_front();
            send = 1'b1;
        end else if (g_mode == 1 && rd_cnt == g_n && perm_q.size() > 0) begin
            tag = perm_q.pop_front();
            send = 1'b1;
        end
        if (send) begin
            line = line_for(int'(tag));
            rd_rsp_valid = 1'b1;
            rd_rsp_mdata = tag;
            rd_rsp_data  = line;
            w.addr = g_dst + 42'(tag);
            w.data = xform(line);
            exp_wr_q.push_back(w);
        end
        for (int i = 0; i < ack_q.size(); i++) if (ack_q[i] > 0) ack_q[i]--;
        if (ack_q.size() > 0 && ack_q[0] == 0) begin
            void'(ack_q.pop_front());
            wr_rsp_valid = 1'b1;
        end
        c1_almfull = (g_c1_hold > 0);
        if (g_c1_hold > 0) g_c1_hold--;
        prev_c1 = c1_almfull;
    endtask

    task automatic start_job(input int n, input logic [41:0] src, input logic [41:0] dst,
                             input logic [41:0] dsm, input int mode);
        g_n = n; g_src = src; g_dst = dst; g_dsm = dsm; g_mode = mode;
        exp_rd_addr_q.delete(); exp_rd_tag_q.delete(); exp_wr_q.delete();
        pend_q.delete(); ack_q.delete();
        rd_cnt = 0; wr_data_cnt = 0; status_cnt = 0; c1_viol = 0; max_inflight = 0;
        for (int i = 0; i < n; i++) begin
            exp_rd_addr_q.push_back(src + 42'(i));
            exp_rd_tag_q.push_back(16'(i));
        end
        num_lines = 16'(n); src_base = src; dst_base = dst; dsm_base = dsm;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            step();
            c++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL done_timeout done=%b required 1 within %0d cycles", done, budget);
        else n_pass++;
    endtask

    task automatic finish_job(input int n);
        n_checks++;
        if (rd_cnt != n) $display("FAIL read_count got=%0d required %0d", rd_cnt, n); else n_pass++;
        n_checks++;
        if (wr_data_cnt != n) $display("FAIL data_write_count got=%0d required %0d", wr_data_cnt, n); else n_pass++;
        n_checks++;
        if (status_cnt != 1) $display("FAIL status_write_count got=%0d required 1", status_cnt); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_in_done got=%b required 0", busy); else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL stop_to_idle done=%b busy=%b required 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_req_valid !== 1'b0 || wr_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rd_req_addr !== '0 || rd_req_mdata !== '0 || wr_req_addr !== '0 || wr_req_data !== '0)
            $display("FAIL reset_state rdv=%b wrv=%b busy=%b done=%b required all 0",
                     rd_req_valid, wr_req_valid, busy, done);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        start_job(4, 42'h100, 42'h200, 42'h1000, 0);
        wait_done(300);
        n_checks++;
        if (first_wr_addr !== 42'h200 || first_wr_data[31:0] !== 32'd10 || first_wr_data[511:480] !== 32'd25)
            $display("FAIL basic_first_write addr=%h lane0=%0d lane15=%0d required 200 10 25",
                     first_wr_addr, first_wr_data[31:0], first_wr_data[511:480]);
        else n_pass++;
        n_checks++;
        if (last_status_data[47:0] !== 48'h0004_0000_0001)
            $display("FAIL basic_status got=%h required 000400000001", last_status_data[47:0]);
        else n_pass++;
        finish_job(4);
    endtask

    task automatic test_out_of_order();
        perm_q = '{16'd7, 16'd3, 16'd0, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4};
        start_job(8, 42'h3_0000, 42'h3FF_FFFF_FFFC, 42'h2000, 1);
        wait_done(400);
        n_checks++;
        if (first_wr_addr !== 42'h003)
            $display("FAIL ooo_first_addr got=%h required 003", first_wr_addr);
        else n_pass++;
        finish_job(8);
    endtask

    task automatic test_credit_limit();
        start_job(40, 42'h4000, 42'h5000, 42'h6000, 2);
        repeat (60) step();
        n_checks++;
        if (rd_cnt != int'(DEPTH)) $display("FAIL credit_reads got=%0d required %0d", rd_cnt, DEPTH);
        else n_pass++;
        g_mode = 0;
        repeat (6) step();
        n_checks++;
        if (rd_cnt <= int'(DEPTH)) $display("FAIL credit_resume got=%0d required >%0d", rd_cnt, DEPTH);
        else n_pass++;
        wait_done(2000);
        n_checks++;
        if (max_inflight != int'(DEPTH)) $display("FAIL credit_max_inflight got=%0d required %0d", max_inflight, DEPTH);
        else n_pass++;
        finish_job(40);
    endtask

    task automatic test_backpressure();
        start_job(40, 42'h7000, 42'h8000, 42'h9000, 0);
        repeat (30) step();
        g_c1_hold = 50;
        num_lines = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (50) step();
        n_checks++;
        if (c1_viol != 0) $display("FAIL c1_hold_writes got=%0d required 0", c1_viol); else n_pass++;
        wait_done(2000);
        n_checks++;
        if (max_inflight > int'(DEPTH)) $display("FAIL bp_inflight got=%0d required <=%0d", max_inflight, DEPTH);
        else n_pass++;
        finish_job(40);
    endtask

    task automatic test_zero_lines();
        start_job(0, 42'hA000, 42'hB000, 42'hC000, 0);
        wait_done(50);
        n_checks++;
        if (last_status_data[47:0] !== 48'h0000_0000_0001)
            $display("FAIL zero_status got=%h required 000000000001", last_status_data[47:0]);
        else n_pass++;
        finish_job(0);
    endtask

    task automatic test_reset_mid_job();
        int c;
        start_job(10, 42'hD000, 42'hE000, 42'hF000, 2);
        c = 0;
        while (rd_cnt < 3 && c < 50) begin
            step();
            c++;
        end
        n_checks++;
        if (rd_cnt != 3) $display("FAIL midreset_reads got=%0d required 3", rd_cnt); else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (rd_req_valid !== 1'b0 || wr_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_state rdv=%b wrv=%b busy=%b done=%b required 0 0 0 0",
                     rd_req_valid, wr_req_valid, busy, done);
        else n_pass++;
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = 16'd1;
        rd_rsp_data  = line_for(1);
        wr_rsp_valid = 1'b1;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || rd_req_valid !== 1'b0 || wr_req_valid !== 1'b0)
            $display("FAIL late_rsp_idle busy=%b rdv=%b wrv=%b required 0 0 0", busy, rd_req_valid, wr_req_valid);
        else n_pass++;
        start_job(10, 42'hD000, 42'hE000, 42'hF000, 0);
        wait_done(500);
        finish_job(10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; num_lines = '0;
        src_base = '0; dst_base = '0; dsm_base = '0;
        c0_almfull = 1'b0; c1_almfull = 1'b0;
        rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0; wr_rsp_valid = 1'b0;
        g_n = 0; g_mode = 0; g_c1_hold = 0; g_src = '0; g_dst = '0; g_dsm = '0;
        rd_cnt = 0; wr_data_cnt = 0; status_cnt = 0; c1_viol = 0; max_inflight = 0;
        prev_c1 = 1'b0; first_wr_addr = '0; first_wr_data = '0; last_status_data = '0;

        test_reset();
        test_basic();
        test_out_of_order();
        test_credit_limit();
        test_backpressure();
        test_zero_lines();
        test_reset_mid_job();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
